// File: rtl/pipe_pkg.sv
// Shared pipeline constants: control field widths, per-stage control bundle widths
// and the bit positions of individual control signals inside a bundle.
package pipe_pkg;

    localparam int WB_CTRL_W = 2;   // reg_write, mem_to_reg
    localparam int M_CTRL_W  = 3;   // branch, mem_read, mem_write
    localparam int EX_CTRL_W = 3;   // alu_src, alu_op[1:0]
    localparam int ZERO_W    = 1;   // ALU zero flag forwarded for branch resolution

    localparam int ID_EX_CTRL_W  = WB_CTRL_W + M_CTRL_W + EX_CTRL_W;
    localparam int EX_MEM_CTRL_W = WB_CTRL_W + M_CTRL_W + ZERO_W;
    localparam int MEM_WB_CTRL_W = WB_CTRL_W;

    localparam int REG_WRITE_BIT  = 0;
    localparam int MEM_TO_REG_BIT = 1;
    localparam int BRANCH_BIT     = 2;
    localparam int MEM_READ_BIT   = 3;
    localparam int MEM_WRITE_BIT  = 4;
    localparam int ZERO_BIT       = 5;

    typedef struct packed {
        logic zero;
        logic mem_write;
        logic mem_read;
        logic branch;
        logic mem_to_reg;
        logic reg_write;
    } ex_mem_ctrl_t;

    // True when a bundle can change architectural state downstream.
    function automatic logic writes_state(input ex_mem_ctrl_t c);
        return c.reg_write | c.mem_write;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer with a registered ready; only built when PIPE_SKID_EN is defined.
// The main entry drives the outputs; the skid entry catches a beat accepted during a stall.
`ifdef PIPE_SKID_EN
module pipe_skid_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_payload,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_payload
);

    logic             main_valid;
    logic             skid_valid;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             in_xfer;
    logic             main_free;

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign out_payload = main_q;
    assign in_xfer     = in_valid && !skid_valid;
    assign main_free   = !main_valid || out_ready;

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (main_free) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_xfer) begin
                main_q     <= in_payload;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid_q is pure storage qualified by skid_valid, so it needs no reset.
    always_ff @(posedge clock) begin
        if (in_xfer && !main_free) begin
            skid_q <= in_payload;
        end
    end

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline register between two RISC-V stages, with flush and a stall counter.
// Define PIPE_SKID_EN to add a second (skid) entry and make in_ready registered.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DATA_N = 3,
    parameter int CTRL_W = EX_MEM_CTRL_W,
    parameter int RD_W   = 5,
    parameter int CNT_W  = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_N*DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0]        in_ctrl,
    input  logic [RD_W-1:0]          in_rd,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_N*DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0]        out_ctrl,
    output logic [RD_W-1:0]          out_rd,
    output logic [CNT_W-1:0]         stall_count
);

    logic stall;

    assign stall = out_valid && !out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= '0;
        end else if (stall && stall_count != '1) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

`ifdef PIPE_SKID_EN
    localparam int BEAT_W = RD_W + CTRL_W + DATA_N * DATA_W;

    logic [BEAT_W-1:0] held_beat;
    logic [CTRL_W-1:0] held_ctrl;

    pipe_skid_buf #(
        .WIDTH (BEAT_W)
    ) u_skid_buf (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_payload  ({in_rd, in_ctrl, in_data}),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_payload (held_beat)
    );

    assign {out_rd, held_ctrl, out_data} = held_beat;
    // A bubble must never present live control to the next stage.
    assign out_ctrl = out_valid ? held_ctrl : '0;
`else
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
            out_data  <= '0;
            out_rd    <= '0;
        end else if (flush) begin
            // An incoming beat is still handshaken upstream but dropped here.
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_ctrl  <= in_ctrl;
            out_data  <= in_data;
            out_rd    <= in_rd;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_ctrl  <= '0;
        end
    end
`endif

endmodule
